dotn_acc: RTL and testbench
===========================

Name: dotn_acc

Overview:
- Parametrised successor to the fixed 16-lane dot product block.
- Computes a signed LANES-wide dot product per beat and accumulates it over a framed sequence of beats (first/last flags).
- Emits one result per sequence with a valid strobe and a beat count.
- Sits between the operand streamers and the result writeback in the dotproduct app.

Parameters:
- DATA_WIDTH, 8, signed operand width.
- LANES, 16, number of multiply lanes; must be a power of two, at least 2.
- MULT_LATENCY, 4, pipeline registers in each multiplier.
- TREE_DELAY, 1, registers per adder-tree level.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(LANES)+8, accumulator and result width; must be at least the tree width.
- CNT_WIDTH, 16, beat-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- ena  in  1  global clock enable; when low, all pipeline state holds.
- in_valid  in  1  beat present on a_in/b_in.
- in_first  in  1  beat opens a new sequence; qualified by in_valid.
- in_last  in  1  beat closes the sequence; qualified by in_valid.
- a_in  in  LANES*DATA_WIDTH  packed signed operands; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_in  in  LANES*DATA_WIDTH  packed signed operands, same lane layout.
- res_out  out  ACC_WIDTH  signed accumulated dot product.
- res_valid  out  1  one-cycle strobe for res_out/res_count.
- res_count  out  CNT_WIDTH  beats in the completed sequence; saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous) clears the following to 0:
  - res_out, res_valid, res_count;
  - the accumulator and the beat counter;
  - the open flag;
  - all valid/first/last pipeline bits.
- Data pipeline registers need no reset.
- Reset mid-sequence discards the partial sum. In-flight beats are lost: their sideband bits are cleared.
- ena=0 freezes every register, including res_valid. A strobe that is high stays high until the next enabled cycle, then drops. In-flight beats are not lost.
- Pipeline, counted in enabled cycles:
  - multiply: MULT_LATENCY;
  - adder tree: $clog2(LANES) levels × TREE_DELAY;
  - accumulate/output register: 1.
- Latency L = MULT_LATENCY + $clog2(LANES)*TREE_DELAY + 1; the default is 9.
- in_valid/in_first/in_last travel in a shift register matched to the data path.
- Widths and arithmetic:
  - products are 2*DATA_WIDTH signed;
  - each tree level grows by 1 bit, so the tree sum is 2*DATA_WIDTH+$clog2(LANES) bits;
  - the tree sum is sign-extended to ACC_WIDTH;
  - the accumulator wraps two's-complement by default.
- Accumulate stage, for an aligned valid beat with tree sum S:
  - first=1, or open=0: acc ← S, cnt ← 1, open ← 1;
  - otherwise: acc ← acc + S, cnt ← cnt + 1 (saturating).
- An aligned non-first beat arriving while open=0 starts an implicit sequence; it is not dropped.
- first=1 while open=1 abandons the old partial sum with no output.
- When an aligned valid beat has last=1:
  - res_out ← the updated acc;
  - res_count ← the updated cnt;
  - res_valid=1 for that cycle;
  - open ← 0.
- first=last=1 on one beat is a single-beat sequence; its result appears L cycles later.
- Invalid aligned slots leave acc/cnt/open unchanged, and res_valid=0.
- res_out/res_count hold their last values between strobes.
- Back-to-back sequences (last then first on consecutive beats) are supported at full rate. There is no backpressure: the sink must accept every strobe.

Optional Feature:
- Macro DOTN_ACC_SAT_EN.
- Defined:
  - accumulator addition saturates to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1);
  - the saturated value persists for subsequent beats of the sequence;
  - the saturation logic adds no pipeline stage, so L is unchanged.
- Undefined: two's-complement wrap, with no extra logic.

Decomposition:
- Package dotn_pkg:
  - function tree_width(DATA_WIDTH, LANES);
  - function latency(MULT_LATENCY, LANES, TREE_DELAY);
  - typedef for the valid/first/last sideband struct;
  - constant default ACC_WIDTH margin (8).
- Sub-module dotn_adder_tree:
  - generate-built registered binary reduction of LANES signed inputs;
  - TREE_DELAY registers per level.
- Multipliers and sideband delay reuse the existing nBit_mLength_shiftRegister for output staging.

Test Plan:
- Single beat, default parameters: all a=1, b=1, first=last=1 → 9 enabled cycles later res_valid=1, res_out=16, res_count=1.
- Extremes: all a=-128, b=-128, single beat → res_out=262144. All a=-128, b=127 → res_out=-260096.
- Sequence of 4 beats (first on beat 0, last on beat 3), lane values a=i, b=2 for i=0..15 → one strobe, res_out=4*240=960, res_count=4; no strobe for beats 0-2.
- ena stall: hold ena=0 for 5 cycles mid-flight of the previous test → same result, strobe 5 cycles later, exactly one strobe.
- ACC_WIDTH=20, three beats of all -128×-128:
  - without the macro: res_out=-262144 (wrap);
  - with DOTN_ACC_SAT_EN: res_out=524287.
- Drive rst=0 asynchronously mid-sequence, then release and send a single beat of all 1s → no stale strobe; next result is 16 with res_count=1.

Source files
------------

// File: rtl/dotn_pkg.sv
// rtl/dotn_pkg.sv - shared widths, latency helpers and sideband type for dotn_acc
package dotn_pkg;

  localparam int ACC_MARGIN = 8;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } side_t;

  function automatic int tree_width(input int data_width, input int lanes);
    return 2 * data_width + $clog2(lanes);
  endfunction

  function automatic int latency(input int mult_latency, input int lanes, input int tree_delay);
    return mult_latency + $clog2(lanes) * tree_delay + 1;
  endfunction

endpackage

// File: rtl/dotn_adder_tree.sv
// rtl/dotn_adder_tree.sv - registered binary reduction of LANES signed inputs, TREE_DELAY regs per level
module dotn_adder_tree #(
  parameter int IN_WIDTH   = 16,
  parameter int LANES      = 16,
  parameter int TREE_DELAY = 1,
  parameter int OUT_WIDTH  = IN_WIDTH + $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [LANES*IN_WIDTH-1:0] in_data,
  output logic [OUT_WIDTH-1:0]      sum_out
);

  localparam int LEVELS = $clog2(LANES);

  // Every level lives in one flat vector; level l starts at node 2*LANES - 2*(LANES>>l).
  // Nodes are carried at full tree width so each pairwise add is exact.
  logic [(2*LANES-1)*OUT_WIDTH-1:0] nodes;

  for (genvar j = 0; j < LANES; j++) begin : g_leaf
    assign nodes[j*OUT_WIDTH +: OUT_WIDTH] =
      OUT_WIDTH'($signed(in_data[j*IN_WIDTH +: IN_WIDTH]));
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NODES     = LANES >> l;
    localparam int BASE      = 2*LANES - 2*NODES;
    localparam int PREV_BASE = 2*LANES - 4*NODES;
    logic [NODES*OUT_WIDTH-1:0] sum;

    for (genvar j = 0; j < NODES; j++) begin : g_add
      assign sum[j*OUT_WIDTH +: OUT_WIDTH] =
        nodes[(PREV_BASE + 2*j)*OUT_WIDTH +: OUT_WIDTH] +
        nodes[(PREV_BASE + 2*j + 1)*OUT_WIDTH +: OUT_WIDTH];
    end

    nBit_mLength_shiftRegister #(.N(NODES*OUT_WIDTH), .M(TREE_DELAY)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .in_data  (sum),
      .out_data (nodes[BASE*OUT_WIDTH +: NODES*OUT_WIDTH])
    );
  end

  assign sum_out = nodes[(2*LANES-2)*OUT_WIDTH +: OUT_WIDTH];

endmodule

// File: rtl/nBit_mLength_shiftRegister.sv
// rtl/nBit_mLength_shiftRegister.sv - N-bit, M-stage enabled shift register, async active-low clear
module nBit_mLength_shiftRegister #(
  parameter int N = 8,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] out_data
);

  generate
    if (M == 0) begin : g_wire
      assign out_data = in_data;
    end else begin : g_regs
      logic [M-1:0][N-1:0] stage_q;
      logic [M-1:0][N-1:0] stage_d;

      always_comb begin
        stage_d = stage_q;
        if (ena) begin
          stage_d[0] = in_data;
          for (int i = 1; i < M; i++) stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) stage_q <= '0;
        else      stage_q <= stage_d;
      end

      assign out_data = stage_q[M-1];
    end
  endgenerate

endmodule

// File: rtl/dotn_acc.sv
// rtl/dotn_acc.sv - framed LANES-wide signed dot-product accumulator; DOTN_ACC_SAT_EN selects saturating accumulation
module dotn_acc
  import dotn_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 16,
  parameter int MULT_LATENCY = 4,
  parameter int TREE_DELAY   = 1,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH + $clog2(LANES) + ACC_MARGIN,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [LANES*DATA_WIDTH-1:0] a_in,
  input  logic [LANES*DATA_WIDTH-1:0] b_in,
  output logic [ACC_WIDTH-1:0]        res_out,
  output logic                        res_valid,
  output logic [CNT_WIDTH-1:0]        res_count
);

  localparam int PW         = 2 * DATA_WIDTH;
  localparam int TW         = tree_width(DATA_WIDTH, LANES);
  localparam int SIDE_DELAY = latency(MULT_LATENCY, LANES, TREE_DELAY) - 1;

  logic [LANES*PW-1:0] prod;
  logic [LANES*PW-1:0] prod_dly;
  logic [TW-1:0]       tree_sum;
  side_t               side_in;
  side_t               side_al;

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    assign a_ext = PW'($signed(a_in[i*DATA_WIDTH +: DATA_WIDTH]));
    assign b_ext = PW'($signed(b_in[i*DATA_WIDTH +: DATA_WIDTH]));
    assign prod[i*PW +: PW] = a_ext * b_ext;
  end

  nBit_mLength_shiftRegister #(.N(LANES*PW), .M(MULT_LATENCY)) u_mul_pipe (
    .clk (clk), .rst (rst), .ena (ena), .in_data (prod), .out_data (prod_dly)
  );

  dotn_adder_tree #(
    .IN_WIDTH (PW), .LANES (LANES), .TREE_DELAY (TREE_DELAY), .OUT_WIDTH (TW)
  ) u_tree (
    .clk (clk), .rst (rst), .ena (ena), .in_data (prod_dly), .sum_out (tree_sum)
  );

  // Sideband rides alongside the data so flags arrive with their own beat's tree sum.
  assign side_in = '{valid: in_valid, first: in_first, last: in_last};

  nBit_mLength_shiftRegister #(.N($bits(side_t)), .M(SIDE_DELAY)) u_side_pipe (
    .clk (clk), .rst (rst), .ena (ena), .in_data (side_in), .out_data (side_al)
  );

  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] x,
                                                   input logic [ACC_WIDTH-1:0] y);
    logic [ACC_WIDTH-1:0] s;
    s = x + y;
`ifdef DOTN_ACC_SAT_EN
    if ((x[ACC_WIDTH-1] == y[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != x[ACC_WIDTH-1]))
      s = x[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif
    return s;
  endfunction

  logic [ACC_WIDTH-1:0] s_ext;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_n;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_n;
  logic                 open_q, open_d;
  logic [ACC_WIDTH-1:0] res_out_q, res_out_d;
  logic [CNT_WIDTH-1:0] res_count_q, res_count_d;
  logic                 res_valid_q, res_valid_d;

  assign s_ext = ACC_WIDTH'($signed(tree_sum));

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    open_d      = open_q;
    res_out_d   = res_out_q;
    res_count_d = res_count_q;
    res_valid_d = 1'b0;
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    if (side_al.valid) begin
      // A stray non-first beat while closed opens an implicit sequence.
      if (side_al.first || !open_q) begin
        acc_n = s_ext;
        cnt_n = CNT_WIDTH'(1);
      end else begin
        acc_n = acc_add(acc_q, s_ext);
        cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      end
      acc_d  = acc_n;
      cnt_d  = cnt_n;
      open_d = 1'b1;
      if (side_al.last) begin
        res_out_d   = acc_n;
        res_count_d = cnt_n;
        res_valid_d = 1'b1;
        open_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      open_q      <= 1'b0;
      res_out_q   <= '0;
      res_count_q <= '0;
      res_valid_q <= 1'b0;
    end else if (ena) begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      res_out_q   <= res_out_d;
      res_count_q <= res_count_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_out   = res_out_q;
  assign res_count = res_count_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_dotn_acc.sv
// tb/tb_dotn_acc.sv - scoreboard bench for dotn_acc, default build and a 20-bit accumulator instance
module tb_dotn_acc;

  localparam int DW   = 8;
  localparam int LN   = 16;
  localparam int W    = DW * LN;
  localparam int L    = 4 + 4 * 1 + 1;
  localparam int AW   = 2*DW + 4 + 8;
  localparam int AW20 = 20;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;

  logic signed [AW-1:0]   res0;
  logic signed [AW20-1:0] res20;
  logic                   v0, v20;
  logic [CW-1:0]          cnt0, cnt20;

  typedef struct {
    longint res;
    int     cnt;
    int     cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q20[$];
  int vectors = 0;
  int miscompares = 0;
  int en_cyc = 0;

`ifdef DOTN_ACC_SAT_EN
  localparam longint EXP20_3BEAT = 524287;
`else
  localparam longint EXP20_3BEAT = -262144;
`endif

  always #5 clk = ~clk;

  dotn_acc dut (
    .clk (clk), .rst (rst), .ena (ena),
    .in_valid (in_valid), .in_first (in_first), .in_last (in_last),
    .a_in (a_in), .b_in (b_in),
    .res_out (res0), .res_valid (v0), .res_count (cnt0)
  );

  dotn_acc #(.ACC_WIDTH(AW20)) dut20 (
    .clk (clk), .rst (rst), .ena (ena),
    .in_valid (in_valid), .in_first (in_first), .in_last (in_last),
    .a_in (a_in), .b_in (b_in),
    .res_out (res20), .res_valid (v20), .res_count (cnt20)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] fill(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] ramp();
    logic [W-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = DW'(i);
    return r;
  endfunction

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic f, input logic l,
                      input bit push, input longint e0, input longint e20, input int ecnt);
    @(negedge clk);
    ena = 1'b1; in_valid = 1'b1; in_first = f; in_last = l; a_in = a; b_in = b;
    if (push) begin
      q0.push_back('{e0, ecnt, en_cyc + L});
      q20.push_back('{e20, ecnt, en_cyc + L});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ena = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(negedge clk);
      ena = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    end
  endtask

  // Strobes are counted only after enabled edges, so a frozen strobe is seen once.
  always @(posedge clk) begin
    logic ena_e;
    exp_t e;
    ena_e = ena;
    #1;
    if (ena_e) en_cyc++;
    if (ena_e && v0) begin
      check("strobe_expected0", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("res_out0", res0, e.res);
        check("res_count0", cnt0, e.cnt);
        check("latency0", en_cyc, e.cyc);
      end
    end
    if (ena_e && v20) begin
      check("strobe_expected20", q20.size() != 0, 1);
      if (q20.size() != 0) begin
        e = q20.pop_front();
        check("res_out20", res20, e.res);
        check("res_count20", cnt20, e.cnt);
        check("latency20", en_cyc, e.cyc);
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res_out0", res0, 0);
    check("rst_res_valid0", v0, 0);
    check("rst_res_count0", cnt0, 0);
    check("rst_res_out20", res20, 0);
    check("rst_res_valid20", v20, 0);
    @(negedge clk);
    rst = 1'b1;

    // single beats, back to back
    beat(fill(1), fill(1), 1, 1, 1, 16, 16, 1);
    beat(fill(-128), fill(-128), 1, 1, 1, 262144, 262144, 1);
    beat(fill(-128), fill(127), 1, 1, 1, -260096, -260096, 1);
    idle(12);

    // four-beat sequence
    beat(ramp(), fill(2), 1, 0, 0, 0, 0, 0);
    beat(ramp(), fill(2), 0, 0, 0, 0, 0, 0);
    beat(ramp(), fill(2), 0, 0, 0, 0, 0, 0);
    beat(ramp(), fill(2), 0, 1, 1, 960, 960, 4);
    idle(12);

    // same sequence with a 5-cycle stall mid-flight
    beat(ramp(), fill(2), 1, 0, 0, 0, 0, 0);
    beat(ramp(), fill(2), 0, 0, 0, 0, 0, 0);
    beat(ramp(), fill(2), 0, 0, 0, 0, 0, 0);
    beat(ramp(), fill(2), 0, 1, 1, 960, 960, 4);
    idle(3);
    stall(5);
    idle(12);

    // strobe frozen by ena=0, drops on the next enabled cycle
    beat(fill(1), fill(1), 1, 1, 1, 16, 16, 1);
    idle(8);
    repeat (3) begin
      @(negedge clk);
      ena = 1'b0; in_valid = 1'b0;
      check("hold_valid0", v0, 1);
      check("hold_valid20", v20, 1);
    end
    idle(1);
    @(negedge clk);
    check("drop_valid0", v0, 0);
    check("drop_valid20", v20, 0);

    // implicit sequence: no first flag while closed
    beat(fill(1), fill(1), 0, 0, 0, 0, 0, 0);
    beat(fill(1), fill(1), 0, 1, 1, 32, 32, 2);
    // first while open abandons the partial sum
    beat(ramp(), fill(2), 1, 0, 0, 0, 0, 0);
    beat(fill(1), fill(1), 1, 1, 1, 16, 16, 1);
    idle(12);

    // three extreme beats: overflows only the 20-bit accumulator
    beat(fill(-128), fill(-128), 1, 0, 0, 0, 0, 0);
    beat(fill(-128), fill(-128), 0, 0, 0, 0, 0, 0);
    beat(fill(-128), fill(-128), 0, 1, 1, 786432, EXP20_3BEAT, 3);
    idle(12);

    // asynchronous reset with a completed beat still in flight
    beat(fill(1), fill(1), 1, 0, 0, 0, 0, 0);
    beat(fill(1), fill(1), 0, 1, 0, 0, 0, 0);
    idle(3);
    #3 rst = 1'b0;
    #1;
    check("midrst_res_out0", res0, 0);
    check("midrst_res_count0", cnt0, 0);
    check("midrst_res_valid0", v0, 0);
    check("midrst_res_out20", res20, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    beat(fill(1), fill(1), 1, 1, 1, 16, 16, 1);
    idle(15);

    check("drain_q0", q0.size(), 0);
    check("drain_q20", q20.size(), 0);
    check("hold_res_out0", res0, 16);
    check("hold_res_count0", cnt0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
